dtcm_arbiter: RTL and testbench
===============================

Name: dtcm_arbiter

Overview:
- Shares the single DTCM port between two requesters: m0 (LSU control path) and m1 (external/debug access port).
- Sits between the requesters and the DTCM.
- Arbitrates commands round-robin and tracks outstanding reads/writes in an in-order route FIFO.
- Steers each DTCM response back to the requester that issued the matching command.

Parameters:
- AW, 16, DTCM address width (matches `DTCM_ADDR_WIDTH).
- DW, 32, data width (matches `XLEN).
- OUTS, 2, maximum outstanding DTCM transactions; route FIFO depth (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock clk, reset rst is synchronous and active-high.
- mX_cmd_valid  input  1  command valid, X in {0,1}.
- mX_cmd_ready  output  1  command accepted.
- mX_cmd_read  input  1  1 = read, 0 = write.
- mX_cmd_addr  input  AW  byte address.
- mX_cmd_wdata  input  DW  write data.
- mX_cmd_wmask  input  DW/8  byte write mask.
- mX_rsp_valid  output  1  response valid.
- mX_rsp_ready  input  1  response accept.
- mX_rsp_rdata  output  DW  read data.
- dtcm_cmd_valid  output  1  command to DTCM.
- dtcm_cmd_ready  input  1  DTCM accepts command.
- dtcm_cmd_read  output  1  read/write select.
- dtcm_cmd_addr  output  AW  address.
- dtcm_cmd_wdata  output  DW  write data.
- dtcm_cmd_wmask  output  DW/8  byte mask.
- dtcm_rsp_valid  input  1  DTCM response valid.
- dtcm_rsp_ready  output  1  response accept toward DTCM.
- dtcm_rsp_rdata  input  DW  read data.
- busy  output  1  outstanding count != 0.
- rsp_err  output  1  sticky: response arrived with empty route FIFO.

Behaviour:
- State registers:
  - rr_ptr (1 bit): preferred master.
  - route FIFO: OUTS entries x 1 bit, holding the grant id.
  - cnt: outstanding count, 0..OUTS.
  - rsp_err.
- Reset: rr_ptr=0, cnt=0, FIFO pointers=0, rsp_err=0. With no inputs active, all valid/ready outputs are 0, busy=0.
- Grant (combinational):
  - can_issue = (cnt < OUTS) | pop_this_cycle.
  - If only one master is valid, it is granted. If both are valid, master rr_ptr is granted. No grant when !can_issue.
- Command mux:
  - dtcm_cmd_* = granted master's fields; dtcm_cmd_valid = granted master's valid & can_issue.
  - m(g)_cmd_ready = dtcm_cmd_ready & can_issue & (g granted). The other master's ready = 0.
  - Zero added latency: command paths are combinational.
- On command handshake: push grant id g into the FIFO and set rr_ptr <= ~g on the next edge. rr_ptr is unchanged when there is no handshake.
- Response routing:
  - Head id h of the FIFO selects the destination.
  - mh_rsp_valid = dtcm_rsp_valid & ~empty; mh_rsp_rdata = dtcm_rsp_rdata. The other master's rsp_valid = 0.
  - Both masters' rsp_rdata = dtcm_rsp_rdata; it is qualified only by valid.
  - dtcm_rsp_ready = mh_rsp_ready when not empty.
  - Pop on dtcm_rsp_valid & dtcm_rsp_ready.
- Write responses are routed identically; rdata is don't-care for writes.
- Push and pop in the same cycle: cnt unchanged, both pointers advance. Pointers wrap modulo OUTS.
- FIFO full (cnt==OUTS) with no pop: both cmd_ready=0 and dtcm_cmd_valid=0. When full and a pop occurs in the same cycle, issue is allowed (pop_this_cycle bypass).
- Empty FIFO with dtcm_rsp_valid=1:
  - dtcm_rsp_ready=1 (response is drained and dropped).
  - No master sees valid.
  - rsp_err <= 1 (sticky until rst).
- Requester rules:
  - A requester must hold cmd fields stable while valid & !ready.
  - The arbiter never drops a granted command mid-handshake: the grant is recomputed each cycle, and a lost grant only means no handshake that cycle.
- Reset mid-operation: FIFO flushed, cnt=0. Responses still in flight from DTCM after reset raise rsp_err. The integration guarantees DTCM is reset together with the arbiter.
- Ordering: DTCM responses are strictly in command order; the arbiter relies on this.

Decomposition:
- Shared package/defines: DTCM_ADDR_WIDTH, XLEN, and master id constants MID_LSU=0, MID_EXT=1.
- One sub-module: dtcm_route_fifo, a 1-bit-wide, OUTS-deep synchronous FIFO.
  - Ports: push, pop, din, dout, empty, full, cnt.
  - Reset: synchronous, active-high.
- Grant/mux logic lives in the top module.

Test Plan:
- Reset then idle → all valid/ready outputs 0, busy=0, rsp_err=0.
- m0 read addr 0x0010 alone, dtcm_cmd_ready=1, DTCM returns 0xDEADBEEF next cycle → m0_rsp_valid=1 with 0xDEADBEEF, m1_rsp_valid=0, cnt back to 0.
- Both masters request continuously, dtcm_cmd_ready=1 → grants alternate m0, m1, m0, m1.
- Response with ready withheld: DTCM responds with m0_rsp_ready=0 for 3 cycles → dtcm_rsp_ready=0 and data held. With OUTS=2, the third command is blocked until the pop, then issues in the same cycle as the pop.
- Interleaved m0 write, m1 read, m0 read; responses A, B, C → A goes to m0, B to m1 with B's rdata, C to m0, in order.
- dtcm_rsp_valid pulse with cnt=0 → no master rsp_valid, dtcm_rsp_ready=1, rsp_err=1 held until rst asserted for one cycle.

Source files
------------

// File: rtl/dtcm_arbiter_pkg.sv
// dtcm_arbiter_pkg
//   Shared widths and master identifiers for the DTCM arbiter slice.
//   DTCM_ADDR_WIDTH : default DTCM byte-address width.
//   XLEN            : default data width.
//   MID_LSU/MID_EXT : route ids stored in the route FIFO (m0 / m1).
package dtcm_arbiter_pkg;

  localparam int DTCM_ADDR_WIDTH = 16;
  localparam int XLEN            = 32;
  localparam int NUM_MASTERS     = 2;

  localparam logic MID_LSU = 1'b0;
  localparam logic MID_EXT = 1'b1;

endpackage

// File: rtl/dtcm_route_fifo.sv
// dtcm_route_fifo
//   1-bit wide, DEPTH-deep synchronous FIFO holding the master id of every
//   outstanding DTCM transaction, oldest at the head.
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   push/din : enqueue din; taken when not full, or when full with a pop
//   pop/dout : dequeue; dout is the current head (valid when !empty)
//   empty, full, cnt : occupancy status
module dtcm_route_fifo #(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] cnt
);

  logic          mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic          push_en;
  logic          pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt_reg == '0);
  assign full  = (cnt_reg == CW'(DEPTH));
  assign cnt   = cnt_reg;
  assign dout  = mem_reg[rd_ptr_reg];

  // A push into a full FIFO is legal only when the head leaves the same edge.
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_en) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push_en, pop_en})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter
//   Shares one DTCM port between m0 (LSU) and m1 (external/debug port).
//   Commands are arbitrated round-robin and passed through combinationally;
//   the id of each issued command is queued so that the in-order DTCM
//   responses can be steered back to their issuer.
//   m0_cmd_* / m1_cmd_* : requester command channels (valid/ready)
//   m0_rsp_* / m1_rsp_* : requester response channels (valid/ready)
//   dtcm_cmd_*, dtcm_rsp_* : DTCM side command / response channels
//   busy    : at least one transaction outstanding
//   rsp_err : sticky, a response arrived with nothing outstanding
module dtcm_arbiter
  import dtcm_arbiter_pkg::*;
#(
  parameter int AW   = DTCM_ADDR_WIDTH,
  parameter int DW   = XLEN,
  parameter int OUTS = 2
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            m0_cmd_valid,
  output logic            m0_cmd_ready,
  input  logic            m0_cmd_read,
  input  logic [AW-1:0]   m0_cmd_addr,
  input  logic [DW-1:0]   m0_cmd_wdata,
  input  logic [DW/8-1:0] m0_cmd_wmask,
  output logic            m0_rsp_valid,
  input  logic            m0_rsp_ready,
  output logic [DW-1:0]   m0_rsp_rdata,

  input  logic            m1_cmd_valid,
  output logic            m1_cmd_ready,
  input  logic            m1_cmd_read,
  input  logic [AW-1:0]   m1_cmd_addr,
  input  logic [DW-1:0]   m1_cmd_wdata,
  input  logic [DW/8-1:0] m1_cmd_wmask,
  output logic            m1_rsp_valid,
  input  logic            m1_rsp_ready,
  output logic [DW-1:0]   m1_rsp_rdata,

  output logic            dtcm_cmd_valid,
  input  logic            dtcm_cmd_ready,
  output logic            dtcm_cmd_read,
  output logic [AW-1:0]   dtcm_cmd_addr,
  output logic [DW-1:0]   dtcm_cmd_wdata,
  output logic [DW/8-1:0] dtcm_cmd_wmask,
  input  logic            dtcm_rsp_valid,
  output logic            dtcm_rsp_ready,
  input  logic [DW-1:0]   dtcm_rsp_rdata,

  output logic            busy,
  output logic            rsp_err
);

  localparam int CW = $clog2(OUTS + 1);

  // Per-master views of the requester ports, indexed by master id.
  logic                   cmd_valid [NUM_MASTERS];
  logic                   cmd_read  [NUM_MASTERS];
  logic [AW-1:0]          cmd_addr  [NUM_MASTERS];
  logic [DW-1:0]          cmd_wdata [NUM_MASTERS];
  logic [DW/8-1:0]        cmd_wmask [NUM_MASTERS];
  logic                   rsp_ready [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] cmd_ready_vec;
  logic [NUM_MASTERS-1:0] rsp_valid_vec;

  logic          rr_ptr_reg;
  logic          rsp_err_reg;
  logic          gnt_id;
  logic          any_valid;
  logic          can_issue;
  logic          cmd_fire;
  logic          pop_fire;
  logic          head_id;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_cnt;

  assign cmd_valid[0] = m0_cmd_valid;
  assign cmd_read[0]  = m0_cmd_read;
  assign cmd_addr[0]  = m0_cmd_addr;
  assign cmd_wdata[0] = m0_cmd_wdata;
  assign cmd_wmask[0] = m0_cmd_wmask;
  assign rsp_ready[0] = m0_rsp_ready;
  assign cmd_valid[1] = m1_cmd_valid;
  assign cmd_read[1]  = m1_cmd_read;
  assign cmd_addr[1]  = m1_cmd_addr;
  assign cmd_wdata[1] = m1_cmd_wdata;
  assign cmd_wmask[1] = m1_cmd_wmask;
  assign rsp_ready[1] = m1_rsp_ready;

  // Round-robin pick: a lone requester always wins; on contention the
  // preferred master (rr_ptr) wins.
  always_comb begin
    gnt_id = MID_LSU;
    if (cmd_valid[0] && cmd_valid[1]) begin
      gnt_id = rr_ptr_reg;
    end else if (cmd_valid[1]) begin
      gnt_id = MID_EXT;
    end
  end

  assign any_valid = cmd_valid[0] | cmd_valid[1];

  // An empty FIFO never pops, so pop_fire only matters when outstanding
  // transactions exist; it lets a full FIFO accept a command the same cycle
  // its head retires.
  assign pop_fire  = dtcm_rsp_valid & dtcm_rsp_ready & ~fifo_empty;
  assign can_issue = ~fifo_full | pop_fire;

  assign dtcm_cmd_valid = any_valid & can_issue;
  assign dtcm_cmd_read  = cmd_read[gnt_id];
  assign dtcm_cmd_addr  = cmd_addr[gnt_id];
  assign dtcm_cmd_wdata = cmd_wdata[gnt_id];
  assign dtcm_cmd_wmask = cmd_wmask[gnt_id];
  assign cmd_fire       = dtcm_cmd_valid & dtcm_cmd_ready;

  // Responses drain unconditionally when nothing is outstanding so a stray
  // response cannot wedge the DTCM; it is flagged through rsp_err instead.
  assign dtcm_rsp_ready = fifo_empty ? dtcm_rsp_valid : rsp_ready[head_id];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    assign cmd_ready_vec[gi] = dtcm_cmd_ready & can_issue & any_valid &
                               (gnt_id == 1'(gi));
    assign rsp_valid_vec[gi] = dtcm_rsp_valid & ~fifo_empty &
                               (head_id == 1'(gi));
  end

  assign m0_cmd_ready = cmd_ready_vec[0];
  assign m1_cmd_ready = cmd_ready_vec[1];
  assign m0_rsp_valid = rsp_valid_vec[0];
  assign m1_rsp_valid = rsp_valid_vec[1];
  assign m0_rsp_rdata = dtcm_rsp_rdata;
  assign m1_rsp_rdata = dtcm_rsp_rdata;

  dtcm_route_fifo #(
    .DEPTH (OUTS)
  ) u_route_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_fire),
    .pop   (pop_fire),
    .din   (gnt_id),
    .dout  (head_id),
    .empty (fifo_empty),
    .full  (fifo_full),
    .cnt   (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= MID_LSU;
      rsp_err_reg <= 1'b0;
    end else begin
      if (cmd_fire) begin
        rr_ptr_reg <= ~gnt_id;
      end
      if (dtcm_rsp_valid && fifo_empty) begin
        rsp_err_reg <= 1'b1;
      end
    end
  end

  assign busy    = (fifo_cnt != '0);
  assign rsp_err = rsp_err_reg;

endmodule

// File: tb/tb_dtcm_arbiter.sv
module tb_dtcm_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [AW-1:0]   m0_cmd_addr;
  logic [DW-1:0]   m0_cmd_wdata;
  logic [DW/8-1:0] m0_cmd_wmask;
  logic            m0_rsp_valid, m0_rsp_ready;
  logic [DW-1:0]   m0_rsp_rdata;
  logic            m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [AW-1:0]   m1_cmd_addr;
  logic [DW-1:0]   m1_cmd_wdata;
  logic [DW/8-1:0] m1_cmd_wmask;
  logic            m1_rsp_valid, m1_rsp_ready;
  logic [DW-1:0]   m1_rsp_rdata;
  logic            dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [AW-1:0]   dtcm_cmd_addr;
  logic [DW-1:0]   dtcm_cmd_wdata;
  logic [DW/8-1:0] dtcm_cmd_wmask;
  logic            dtcm_rsp_valid, dtcm_rsp_ready;
  logic [DW-1:0]   dtcm_rsp_rdata;
  logic            busy, rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  dtcm_arbiter #(.AW(AW), .DW(DW), .OUTS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_cmd_valid   (m0_cmd_valid),
    .m0_cmd_ready   (m0_cmd_ready),
    .m0_cmd_read    (m0_cmd_read),
    .m0_cmd_addr    (m0_cmd_addr),
    .m0_cmd_wdata   (m0_cmd_wdata),
    .m0_cmd_wmask   (m0_cmd_wmask),
    .m0_rsp_valid   (m0_rsp_valid),
    .m0_rsp_ready   (m0_rsp_ready),
    .m0_rsp_rdata   (m0_rsp_rdata),
    .m1_cmd_valid   (m1_cmd_valid),
    .m1_cmd_ready   (m1_cmd_ready),
    .m1_cmd_read    (m1_cmd_read),
    .m1_cmd_addr    (m1_cmd_addr),
    .m1_cmd_wdata   (m1_cmd_wdata),
    .m1_cmd_wmask   (m1_cmd_wmask),
    .m1_rsp_valid   (m1_rsp_valid),
    .m1_rsp_ready   (m1_rsp_ready),
    .m1_rsp_rdata   (m1_rsp_rdata),
    .dtcm_cmd_valid (dtcm_cmd_valid),
    .dtcm_cmd_ready (dtcm_cmd_ready),
    .dtcm_cmd_read  (dtcm_cmd_read),
    .dtcm_cmd_addr  (dtcm_cmd_addr),
    .dtcm_cmd_wdata (dtcm_cmd_wdata),
    .dtcm_cmd_wmask (dtcm_cmd_wmask),
    .dtcm_rsp_valid (dtcm_rsp_valid),
    .dtcm_rsp_ready (dtcm_rsp_ready),
    .dtcm_rsp_rdata (dtcm_rsp_rdata),
    .busy           (busy),
    .rsp_err        (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("chk  %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    m0_cmd_valid = 0; m0_cmd_read = 0; m0_cmd_addr = '0; m0_cmd_wdata = '0;
    m0_cmd_wmask = '0; m0_rsp_ready = 0;
    m1_cmd_valid = 0; m1_cmd_read = 0; m1_cmd_addr = '0; m1_cmd_wdata = '0;
    m1_cmd_wmask = '0; m1_rsp_ready = 0;
    dtcm_cmd_ready = 0; dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #2;
    // Idle after reset
    check("idle_m0_cmd_ready", 32'(m0_cmd_ready), 0);
    check("idle_m1_cmd_ready", 32'(m1_cmd_ready), 0);
    check("idle_m0_rsp_valid", 32'(m0_rsp_valid), 0);
    check("idle_m1_rsp_valid", 32'(m1_rsp_valid), 0);
    check("idle_dtcm_cmd_valid", 32'(dtcm_cmd_valid), 0);
    check("idle_dtcm_rsp_ready", 32'(dtcm_rsp_ready), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_rsp_err", 32'(rsp_err), 0);

    // Single m0 read, response next cycle
    tick();
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0010; dtcm_cmd_ready = 1;
    #2;
    check("rd_dtcm_cmd_valid", 32'(dtcm_cmd_valid), 1);
    check("rd_dtcm_cmd_addr", 32'(dtcm_cmd_addr), 32'h10);
    check("rd_dtcm_cmd_read", 32'(dtcm_cmd_read), 1);
    check("rd_m0_cmd_ready", 32'(m0_cmd_ready), 1);
    check("rd_m1_cmd_ready", 32'(m1_cmd_ready), 0);
    tick();
    m0_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'hDEADBEEF; m0_rsp_ready = 1;
    #2;
    check("rd_busy", 32'(busy), 1);
    check("rd_m0_rsp_valid", 32'(m0_rsp_valid), 1);
    check("rd_m0_rsp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    check("rd_m1_rsp_valid", 32'(m1_rsp_valid), 0);
    check("rd_dtcm_rsp_ready", 32'(dtcm_rsp_ready), 1);
    tick();
    dtcm_rsp_valid = 0; m0_rsp_ready = 0;
    #2;
    check("rd_busy_after", 32'(busy), 0);

    // Both masters request continuously: grants alternate m0,m1,m0,m1
    do_reset();
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0100;
    m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 16'h0200;
    dtcm_cmd_ready = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      dtcm_rsp_valid = (k > 0);
      dtcm_rsp_rdata = 32'(k);
      #2;
      check($sformatf("rr%0d_m0_cmd_ready", k), 32'(m0_cmd_ready), 32'((k % 2) == 0));
      check($sformatf("rr%0d_m1_cmd_ready", k), 32'(m1_cmd_ready), 32'((k % 2) == 1));
      check($sformatf("rr%0d_addr", k), 32'(dtcm_cmd_addr), (k % 2) ? 32'h200 : 32'h100);
      if (k > 0) begin
        check($sformatf("rr%0d_m1_rsp_valid", k), 32'(m1_rsp_valid), 32'(((k - 1) % 2) == 1));
        check($sformatf("rr%0d_m0_rsp_valid", k), 32'(m0_rsp_valid), 32'(((k - 1) % 2) == 0));
      end
      tick();
    end
    m0_cmd_valid = 0; m1_cmd_valid = 0; dtcm_rsp_valid = 1;
    #2;
    check("rr_drain_m1_rsp_valid", 32'(m1_rsp_valid), 1);
    tick();
    dtcm_rsp_valid = 0;
    #2;
    check("rr_busy_after", 32'(busy), 0);

    // Response ready withheld while FIFO full; third command waits for the pop
    do_reset();
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0020; dtcm_cmd_ready = 1;
    #2;
    check("hold_cmd1_m0_ready", 32'(m0_cmd_ready), 1);
    tick();
    m0_cmd_valid = 0; m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 16'h0024;
    #2;
    check("hold_cmd2_m1_ready", 32'(m1_cmd_ready), 1);
    tick();
    m1_cmd_valid = 0; m0_cmd_valid = 1; m0_cmd_addr = 16'h0028;
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h11111111; m0_rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("hold%0d_dtcm_rsp_ready", k), 32'(dtcm_rsp_ready), 0);
      check($sformatf("hold%0d_m0_rsp_valid", k), 32'(m0_rsp_valid), 1);
      check($sformatf("hold%0d_m0_rsp_rdata", k), m0_rsp_rdata, 32'h11111111);
      check($sformatf("hold%0d_dtcm_cmd_valid", k), 32'(dtcm_cmd_valid), 0);
      check($sformatf("hold%0d_m0_cmd_ready", k), 32'(m0_cmd_ready), 0);
      tick();
    end
    m0_rsp_ready = 1;
    #2;
    check("hold_pop_dtcm_rsp_ready", 32'(dtcm_rsp_ready), 1);
    check("hold_bypass_dtcm_cmd_valid", 32'(dtcm_cmd_valid), 1);
    check("hold_bypass_m0_cmd_ready", 32'(m0_cmd_ready), 1);
    check("hold_bypass_addr", 32'(dtcm_cmd_addr), 32'h28);
    tick();
    m0_cmd_valid = 0; dtcm_rsp_rdata = 32'h22222222; m1_rsp_ready = 1;
    #2;
    check("hold_r2_m1_rsp_valid", 32'(m1_rsp_valid), 1);
    check("hold_r2_m0_rsp_valid", 32'(m0_rsp_valid), 0);
    check("hold_r2_m1_rsp_rdata", m1_rsp_rdata, 32'h22222222);
    tick();
    dtcm_rsp_rdata = 32'h33333333;
    #2;
    check("hold_r3_m0_rsp_valid", 32'(m0_rsp_valid), 1);
    check("hold_r3_m1_rsp_valid", 32'(m1_rsp_valid), 0);
    tick();
    dtcm_rsp_valid = 0;
    #2;
    check("hold_busy_after", 32'(busy), 0);

    // Interleaved m0 write, m1 read, m0 read; responses A, B, C in order
    do_reset();
    m0_cmd_valid = 1; m0_cmd_read = 0; m0_cmd_addr = 16'h0040;
    m0_cmd_wdata = 32'hCAFEF00D; m0_cmd_wmask = 4'b0101; dtcm_cmd_ready = 1;
    #2;
    check("il_wr_read", 32'(dtcm_cmd_read), 0);
    check("il_wr_wdata", dtcm_cmd_wdata, 32'hCAFEF00D);
    check("il_wr_wmask", 32'(dtcm_cmd_wmask), 32'h5);
    tick();
    m0_cmd_valid = 0; m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 16'h0044;
    #2;
    check("il_rd1_read", 32'(dtcm_cmd_read), 1);
    check("il_rd1_m1_ready", 32'(m1_cmd_ready), 1);
    tick();
    m1_cmd_valid = 0; m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0048;
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h0; m0_rsp_ready = 1; m1_rsp_ready = 1;
    #2;
    check("il_A_m0_rsp_valid", 32'(m0_rsp_valid), 1);
    check("il_A_m1_rsp_valid", 32'(m1_rsp_valid), 0);
    check("il_rd2_m0_ready", 32'(m0_cmd_ready), 1);
    tick();
    m0_cmd_valid = 0; dtcm_rsp_rdata = 32'hB0B0B0B0;
    #2;
    check("il_B_m1_rsp_valid", 32'(m1_rsp_valid), 1);
    check("il_B_m0_rsp_valid", 32'(m0_rsp_valid), 0);
    check("il_B_m1_rsp_rdata", m1_rsp_rdata, 32'hB0B0B0B0);
    tick();
    dtcm_rsp_rdata = 32'h0C0C0C0C;
    #2;
    check("il_C_m0_rsp_valid", 32'(m0_rsp_valid), 1);
    check("il_C_m1_rsp_valid", 32'(m1_rsp_valid), 0);
    check("il_C_m0_rsp_rdata", m0_rsp_rdata, 32'h0C0C0C0C);
    tick();
    dtcm_rsp_valid = 0;
    #2;
    check("il_busy_after", 32'(busy), 0);
    check("il_rsp_err", 32'(rsp_err), 0);

    // Stray response with nothing outstanding
    idle();
    tick();
    dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h5A5A5A5A;
    #2;
    check("err_m0_rsp_valid", 32'(m0_rsp_valid), 0);
    check("err_m1_rsp_valid", 32'(m1_rsp_valid), 0);
    check("err_dtcm_rsp_ready", 32'(dtcm_rsp_ready), 1);
    tick();
    dtcm_rsp_valid = 0;
    #2;
    check("err_rsp_err_set", 32'(rsp_err), 1);
    tick();
    tick();
    check("err_rsp_err_sticky", 32'(rsp_err), 1);
    do_reset();
    #2;
    check("err_rsp_err_cleared", 32'(rsp_err), 0);
    check("err_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
